// File: rtl/bubble_sort_seq_if.sv
// bubble_sort_seq_if
//   Stream bundle for the sequential bubble sorter: one valid/ready input
//   stream carrying unsorted elements and one valid/ready output stream
//   carrying the sorted frame with a last marker.
//
//   Signals:
//     in_valid  - producer has an element on in_data
//     in_ready  - sorter accepts an element this cycle
//     in_data   - input element (WIDTH bits, unsigned)
//     out_valid - sorter has a sorted element on out_data
//     out_ready - consumer accepts this cycle
//     out_data  - sorted element (WIDTH bits)
//     out_last  - marks the final (largest) element of the frame
//
//   Modports:
//     master - the environment side (drives inputs, consumes outputs)
//     slave  - the sorter side
interface bubble_sort_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/bubble_sort_seq.sv
// bubble_sort_seq
//   Single-comparator bubble sorter. Loads DIM unsigned elements from the
//   input stream into an internal buffer, sorts them in place with one
//   compare/swap per clock (early exit when a pass makes no swap), then
//   drains them in ascending order on the output stream.
//
//   Parameters:
//     DIM   - elements per frame (2..256)
//     WIDTH - element width in bits
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - stream bundle (slave side), see bubble_sort_seq_if
//     busy - high while sorting or draining
module bubble_sort_seq #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  bubble_sort_seq_if.slave    bus,
  output logic                busy
);

  localparam int IW = $clog2(DIM);

  localparam logic [IW-1:0] LAST_IDX  = IW'(DIM - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(DIM - 2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DIM];
  logic [IW-1:0]    cnt;
  logic [IW-1:0]    pass;
  logic [IW-1:0]    j;
  logic [IW-1:0]    q;
  logic             swapped;

  logic             out_valid_r;
  logic             out_last_r;
  logic [WIDTH-1:0] out_data_r;

  // Comparator datapath: the single pair under inspection this cycle.
  logic [IW-1:0]    j_next;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             do_swap;
  logic             end_of_pass;

  always_comb begin
    j_next      = j + IW'(1);
    cmp_a       = mem[j];
    cmp_b       = mem[j_next];
    // Strict compare keeps equal elements in place, so the sort is stable.
    do_swap     = cmp_a > cmp_b;
    // Each pass shrinks by one: the tail already holds the largest values.
    end_of_pass = (j == (LAST_PASS - pass));
  end

  // Handshake decode depends only on registered state, never on the
  // partner's valid/ready.
  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_data  = out_data_r;
  assign busy          = (state != LOAD);

  // Main sequencer: load, sort and drain share one register process so the
  // output registers are updated on exactly the same edges as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      pass        <= '0;
      j           <= '0;
      q           <= '0;
      swapped     <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      for (int i = 0; i < DIM; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (bus.in_valid) begin
            mem[cnt] <= bus.in_data;
            if (cnt == LAST_IDX) begin
              state   <= SORT;
              cnt     <= '0;
              pass    <= '0;
              j       <= '0;
              swapped <= 1'b0;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end

        SORT: begin
          if (do_swap) begin
            mem[j]      <= cmp_b;
            mem[j_next] <= cmp_a;
          end
          if (end_of_pass) begin
            if (!(swapped || do_swap) || (pass == LAST_PASS)) begin
              state       <= DRAIN;
              q           <= '0;
              out_valid_r <= 1'b1;
              out_last_r  <= 1'b0;
              // The final compare may be swapping element 0 on this very
              // edge, so take the post-swap value rather than mem[0].
              out_data_r  <= ((j == '0) && do_swap) ? cmp_b : mem[0];
            end else begin
              pass    <= pass + IW'(1);
              j       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            j       <= j_next;
            swapped <= swapped | do_swap;
          end
        end

        DRAIN: begin
          if (out_valid_r && bus.out_ready) begin
            if (q == LAST_IDX) begin
              state       <= LOAD;
              q           <= '0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_data_r  <= '0;
            end else begin
              q          <= q + IW'(1);
              out_data_r <= mem[q + IW'(1)];
              out_last_r <= ((q + IW'(1)) == LAST_IDX);
            end
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_seq.sv
// tb_bubble_sort_seq
//   Self-checking bench for bubble_sort_seq (DIM=4, WIDTH=8). Frames come
//   from a table of {input frame, sorted frame, compare count, output
//   pacing, input noise}; the sorted frame is pushed to a scoreboard when
//   the frame is driven and popped as the DUT emits elements. A hand-written
//   sequence covers reset asserted in the middle of sorting.
module tb_bubble_sort_seq;

  localparam int DIM   = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   cyc = 0;

  int total  = 0;
  int passed = 0;

  logic [WIDTH-1:0] sb [$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    int          k;
    int          mode;
    bit          noise;
  } vec_t;

  vec_t tbl [7];

  bubble_sort_seq_if #(.WIDTH(WIDTH)) bus ();

  bubble_sort_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Free-running clock and an edge counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] elem(input logic [31:0] v, input int i);
    return v[8*(3-i) +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one frame with in_valid held high and queue its sorted image.
  task automatic applyStimulus(input logic [31:0] din, input logic [31:0] dout,
                               output int last_cyc);
    int n;
    last_cyc = cyc;
    for (int e = 0; e < DIM; e++) sb.push_back(elem(dout, e));
    for (int e = 0; e < DIM; e++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = elem(din, e);
      n = 0;
      while (!bus.in_ready && n < 50) begin
        tick();
        n++;
      end
      if (!bus.in_ready) begin
        check("in_accept_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      tick();
      last_cyc = cyc;
    end
    bus.in_valid = 1'b0;
    check("in_ready_after_last", 32'(bus.in_ready), 32'd0);
    check("busy_after_last", 32'(busy), 32'd1);
  endtask

  // Wait for the sorted frame, measure latency and drain it with the
  // requested out_ready pacing, optionally spraying in_valid meanwhile.
  task automatic checkOutput(input int k, input int mode, input bit noise,
                             input int last_cyc);
    int  n;
    int  count;
    int  i;
    logic rdy;
    logic [WIDTH-1:0] exp;
    bus.out_ready = (mode == 0);
    if (noise) bus.in_valid = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      if (noise) begin
        check("in_ready_sort", 32'(bus.in_ready), 32'd0);
        bus.in_data = 8'($urandom);
      end
      tick();
      n++;
    end
    check("out_valid_rise", 32'(bus.out_valid), 32'd1);
    if (!bus.out_valid) begin
      bus.in_valid = 1'b0;
      sb.delete();
      return;
    end
    check("latency", 32'(cyc - last_cyc), 32'(k));
    count = 0;
    i = 0;
    while (count < DIM && i < 200) begin
      if (mode == 0) rdy = 1'b1;
      else rdy = (i < 5) ? 1'b0 : (((i - 5) % 2) == 0);
      bus.out_ready = rdy;
      if (noise) begin
        check("in_ready_drain", 32'(bus.in_ready), 32'd0);
        bus.in_data = 8'($urandom);
      end
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 32'(sb.size()), 32'd1);
        break;
      end
      check("out_valid_drain", 32'(bus.out_valid), 32'd1);
      if (rdy) begin
        exp = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(exp));
        check("out_last", 32'(bus.out_last), 32'(count == DIM - 1));
        count++;
      end else begin
        exp = sb[0];
        check("out_data_stall", 32'(bus.out_data), 32'(exp));
        check("out_last_stall", 32'(bus.out_last), 32'(count == DIM - 1));
      end
      tick();
      i++;
    end
    bus.in_valid = 1'b0;
    check("drain_count", 32'(count), 32'(DIM));
    check("in_ready_after_drain", 32'(bus.in_ready), 32'd1);
    check("busy_after_drain", 32'(busy), 32'd0);
    check("out_valid_after_drain", 32'(bus.out_valid), 32'd0);
    sb.delete();
  endtask

  initial begin
    int last_cyc;

    tbl[0] = '{din: 32'h01020304, dout: 32'h01020304, k: 3, mode: 0, noise: 1'b0};
    tbl[1] = '{din: 32'hC8966432, dout: 32'h326496C8, k: 6, mode: 0, noise: 1'b0};
    tbl[2] = '{din: 32'h07030703, dout: 32'h03030707, k: 6, mode: 0, noise: 1'b0};
    tbl[3] = '{din: 32'h0900FF04, dout: 32'h000409FF, k: 6, mode: 1, noise: 1'b0};
    tbl[4] = '{din: 32'h04010203, dout: 32'h01020304, k: 5, mode: 0, noise: 1'b1};
    tbl[5] = '{din: 32'h05060708, dout: 32'h05060708, k: 3, mode: 0, noise: 1'b0};
    tbl[6] = '{din: 32'h03030303, dout: 32'h03030303, k: 3, mode: 1, noise: 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      applyStimulus(tbl[v].din, tbl[v].dout, last_cyc);
      checkOutput(tbl[v].k, tbl[v].mode, tbl[v].noise, last_cyc);
    end

    // Reset during the second compare cycle of a reverse-ordered frame.
    applyStimulus(32'h04030201, 32'h01020304, last_cyc);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);
    applyStimulus(32'h0A1E1428, 32'h0A141E28, last_cyc);
    checkOutput(5, 0, 1'b0, last_cyc);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
